// File: rtl/present_bus_pkg.sv
// Shared definitions for the PRESENT peripheral bus master: register map,
// mode encodings, controller states and the registered bus bundle.
package present_bus_pkg;

   localparam logic [3:0] ADDR_LOAD   = 4'h0;
   localparam logic [3:0] ADDR_KEY0   = 4'h1;
   localparam logic [3:0] ADDR_KEY1   = 4'h2;
   localparam logic [3:0] ADDR_KEY2   = 4'h3;
   localparam logic [3:0] ADDR_DAT0   = 4'h4;
   localparam logic [3:0] ADDR_DAT1   = 4'h5;
   localparam logic [3:0] ADDR_ENC_LO = 4'h6;
   localparam logic [3:0] ADDR_ENC_HI = 4'h7;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;
   localparam logic [3:0] ADDR_DM_LO  = 4'h9;
   localparam logic [3:0] ADDR_DM_HI  = 4'hA;

   typedef enum logic [1:0] {
      MODE_ENC = 2'd0,
      MODE_DEC = 2'd1,
      MODE_DM  = 2'd2,
      MODE_RSV = 2'd3
   } mode_t;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_K2, S_WR_K1, S_WR_K0, S_WR_D1, S_WR_D0, S_WR_CTRL,
      S_WR_LOAD, S_RELEASE, S_WAIT, S_RD_HI, S_RD_LO, S_CAP_LO, S_RESP
   } state_t;

   typedef struct packed {
      logic        cs_n;
      logic        write_n;
      logic        read_n;
      logic [3:0]  addr;
      logic [31:0] wdat;
   } bus_t;

   localparam bus_t BUS_IDLE = '{cs_n: 1'b1, write_n: 1'b1, read_n: 1'b1,
                                 addr: 4'h0, wdat: 32'h0};

   function automatic bus_t bus_wr(input logic [3:0] a, input logic [31:0] d);
      bus_wr = '{cs_n: 1'b0, write_n: 1'b0, read_n: 1'b1, addr: a, wdat: d};
   endfunction

   function automatic bus_t bus_rd(input logic [3:0] a);
      bus_rd = '{cs_n: 1'b0, write_n: 1'b1, read_n: 1'b0, addr: a, wdat: 32'h0};
   endfunction

endpackage

// File: rtl/present_bus_master.sv
// Bus initiator that programs the PRESENT peripheral from a request port,
// waits out the cipher, reads the result back and offers it on a response port.
module present_bus_master
   import present_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 80
) (
   input  logic        clk,
   input  logic        iReset,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic [79:0] iReqKey,
   input  logic [63:0] iReqBlock,
   input  logic [1:0]  iReqMode,
   output logic        oRspValid,
   input  logic        iRspReady,
   output logic [63:0] oRspData,
   output logic        oChipselect_n,
   output logic        oWrite_n,
   output logic        oRead_n,
   output logic [3:0]  oAddress,
   output logic [31:0] oWdat,
   input  logic [31:0] iRdat
);

   localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

   state_t      state, nxt;
   bus_t        bus_q, bus_d;
   logic [79:0] key_q, key_src;
   logic [63:0] blk_q;
   mode_t       mode_q;
   logic [7:0]  wait_cnt;
   logic [63:0] rsp_data;
   logic        rsp_valid;
   logic        dm;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (iReqValid) nxt = S_WR_K2;
         S_WR_K2:   nxt = S_WR_K1;
         S_WR_K1:   nxt = S_WR_K0;
         S_WR_K0:   nxt = S_WR_D1;
         S_WR_D1:   nxt = S_WR_D0;
         S_WR_D0:   nxt = S_WR_CTRL;
         S_WR_CTRL: nxt = S_WR_LOAD;
         S_WR_LOAD: nxt = S_RELEASE;
         S_RELEASE: nxt = S_WAIT;
         S_WAIT:    if (wait_cnt == 8'd0) nxt = S_RD_HI;
         S_RD_HI:   nxt = S_RD_LO;
         S_RD_LO:   nxt = S_CAP_LO;
         S_CAP_LO:  nxt = S_RESP;
         S_RESP:    if (iRspReady) nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   // Bus outputs are decoded from the next state so the registered strobes
   // line up with the state that owns them; the first key word comes straight
   // from the request because it is not latched yet.
   assign key_src = (state == S_IDLE) ? iReqKey : key_q;
   assign dm      = (mode_q == MODE_DM);

   always_comb begin
      bus_d = BUS_IDLE;
      case (nxt)
         S_WR_K2:   bus_d = bus_wr(ADDR_KEY2, key_src[79:48]);
         S_WR_K1:   bus_d = bus_wr(ADDR_KEY1, key_q[47:16]);
         S_WR_K0:   bus_d = bus_wr(ADDR_KEY0, {16'h0, key_q[15:0]});
         S_WR_D1:   bus_d = bus_wr(ADDR_DAT1, blk_q[63:32]);
         S_WR_D0:   bus_d = bus_wr(ADDR_DAT0, blk_q[31:0]);
         S_WR_CTRL: bus_d = bus_wr(ADDR_CTRL, {31'h0, mode_q == MODE_DEC});
         S_WR_LOAD: bus_d = bus_wr(ADDR_LOAD, 32'h1);
         S_RELEASE: bus_d.cs_n = 1'b0;
         S_RD_HI:   bus_d = bus_rd(dm ? ADDR_DM_HI : ADDR_ENC_HI);
         S_RD_LO:   bus_d = bus_rd(dm ? ADDR_DM_LO : ADDR_ENC_LO);
         default:   bus_d = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) begin
         state     <= S_IDLE;
         bus_q     <= BUS_IDLE;
         key_q     <= '0;
         blk_q     <= '0;
         mode_q    <= MODE_ENC;
         wait_cnt  <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= nxt;
         bus_q     <= bus_d;
         rsp_valid <= (nxt == S_RESP);
         if (state == S_IDLE && iReqValid) begin
            key_q  <= iReqKey;
            blk_q  <= iReqBlock;
            mode_q <= mode_t'(iReqMode);
         end
         if (state == S_RELEASE)   wait_cnt <= WAIT_LOAD;
         else if (state == S_WAIT) wait_cnt <= wait_cnt - 8'd1;
         // Slave read data lags the strobe by one cycle.
         if (state == S_RD_LO)  rsp_data[63:32] <= iRdat;
         if (state == S_CAP_LO) rsp_data[31:0]  <= iRdat;
      end
   end

   assign oReqReady     = (state == S_IDLE);
   assign oRspValid     = rsp_valid;
   assign oRspData      = rsp_data;
   assign oChipselect_n = bus_q.cs_n;
   assign oWrite_n      = bus_q.write_n;
   assign oRead_n       = bus_q.read_n;
   assign oAddress      = bus_q.addr;
   assign oWdat         = bus_q.wdat;

endmodule

// File: tb/tb_present_bus_master.sv
// Bench: master driving a behavioural PRESENT peripheral, with a bus monitor
// and a response scoreboard.
module tb_present_bus_master;

   localparam int WAIT_CYCLES = 80;
   localparam int LAT = 12 + WAIT_CYCLES;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [79:0] req_key;
   logic [63:0] req_blk, rsp_data, exp_next;
   logic [1:0]  req_mode;
   logic        cs_n, wr_n, rd_n;
   logic [3:0]  addr;
   logic [31:0] wdat, rdat;

   always #5 clk = ~clk;

   present_bus_master #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .iReset(rst),
      .iReqValid(req_valid), .oReqReady(req_ready),
      .iReqKey(req_key), .iReqBlock(req_blk), .iReqMode(req_mode),
      .oRspValid(rsp_valid), .iRspReady(rsp_ready), .oRspData(rsp_data),
      .oChipselect_n(cs_n), .oWrite_n(wr_n), .oRead_n(rd_n),
      .oAddress(addr), .oWdat(wdat), .iRdat(rdat)
   );

   int errs = 0, chks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- PRESENT-80 reference ----------------
   localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   function automatic logic [3:0] isb(input logic [3:0] x);
      isb = 4'h0;
      for (int i = 0; i < 16; i++) if (SBOX[i] == x) isb = 4'(i);
   endfunction

   function automatic logic [63:0] sl(input logic [63:0] s, input bit inv);
      for (int i = 0; i < 16; i++) sl[4*i +: 4] = inv ? isb(s[4*i +: 4]) : SBOX[s[4*i +: 4]];
   endfunction

   function automatic logic [63:0] pl(input logic [63:0] s, input bit inv);
      pl[63] = s[63];
      for (int i = 0; i < 63; i++)
         if (inv) pl[i] = s[(16*i) % 63];
         else     pl[(16*i) % 63] = s[i];
   endfunction

   function automatic logic [79:0] ku(input logic [79:0] k, input int rc);
      ku = {k[18:0], k[79:19]};
      ku[79:76] = SBOX[ku[79:76]];
      ku[19:15] = ku[19:15] ^ 5'(rc);
   endfunction

   function automatic logic [63:0] enc(input logic [79:0] key, input logic [63:0] blk);
      logic [79:0] k = key;
      enc = blk;
      for (int r = 1; r <= 31; r++) begin
         enc = pl(sl(enc ^ k[79:16], 1'b0), 1'b0);
         k = ku(k, r);
      end
      enc = enc ^ k[79:16];
   endfunction

   function automatic logic [63:0] dec(input logic [79:0] key, input logic [63:0] blk);
      logic [63:0] rk [33];
      logic [79:0] k = key;
      for (int r = 1; r <= 32; r++) begin
         rk[r] = k[79:16];
         if (r < 32) k = ku(k, r);
      end
      dec = blk ^ rk[32];
      for (int r = 31; r >= 1; r--) dec = sl(pl(dec, 1'b1), 1'b1) ^ rk[r];
   endfunction

   // ---------------- peripheral model ----------------
   logic [31:0] sk0, sk1, sk2, sd0, sd1, sctrl;
   logic [63:0] s_enc, s_dm;
   logic        s_load;
   int          s_timer;

   function automatic logic [31:0] sreg(input logic [3:0] a);
      case (a)
         4'h6:    sreg = s_enc[31:0];
         4'h7:    sreg = s_enc[63:32];
         4'h9:    sreg = s_dm[31:0];
         4'hA:    sreg = s_dm[63:32];
         default: sreg = 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         {sk0, sk1, sk2, sd0, sd1, sctrl} <= '0;
         s_enc <= '0; s_dm <= '0; s_load <= 1'b0; s_timer <= 0; rdat <= '0;
      end else begin
         s_timer <= s_timer + 1;
         if (!cs_n && !wr_n) begin
            case (addr)
               4'h1: sk0 <= wdat;
               4'h2: sk1 <= wdat;
               4'h3: sk2 <= wdat;
               4'h4: sd0 <= wdat;
               4'h5: sd1 <= wdat;
               4'h8: sctrl <= wdat;
               4'h0: begin
                  s_load <= wdat[0];
                  if (wdat[0]) begin
                     s_enc <= sctrl[0] ? dec({sk2, sk1, sk0[15:0]}, {sd1, sd0})
                                       : enc({sk2, sk1, sk0[15:0]}, {sd1, sd0});
                     s_dm  <= enc({sk2, sk1, sk0[15:0]}, {sd1, sd0}) ^ {sd1, sd0};
                     s_timer <= 0;
                  end
               end
               default: ;
            endcase
         end else if (!cs_n && wr_n && rd_n) s_load <= 1'b0;
         // Results read before the cipher could have finished come back as junk.
         if (!cs_n && !rd_n) rdat <= (s_timer < 72) ? 32'hDEAD_BEEF : sreg(addr);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   typedef struct packed {logic cs; logic wr; logic rd; logic [3:0] a; logic [31:0] d;} ent_t;
   ent_t        log_q[$];
   logic [63:0] exp_q[$];
   int cyc = 0, acc_cyc = 0, hs_cyc = 0, acc_cnt = 0, rsp_cnt = 0, load_cnt = 0, bus_viol = 0;
   bit log_on = 0, rsp_vld_d = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_q.delete(); log_on = 0; rsp_vld_d = 0;
      end else begin
         if (!wr_n && !rd_n) bus_viol++;
         if (wr_n && wdat != 32'h0) bus_viol++;
         if (cs_n && (!wr_n || !rd_n)) bus_viol++;
         if (s_load) load_cnt++;
         if (log_on) log_q.push_back('{cs_n, wr_n, rd_n, addr, wdat});
         if (rsp_valid && !rsp_vld_d) begin
            chk("latency", 64'(cyc - acc_cyc + 1), 64'(LAT));
            log_on = 0;
         end
         rsp_vld_d = rsp_valid;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
            else chk("rsp_data", rsp_data, exp_q.pop_front());
            rsp_cnt++;
            hs_cyc = cyc + 1;
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(exp_next);
            acc_cyc = cyc + 1;
            acc_cnt++;
            log_q.delete(); log_on = 1; load_cnt = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [79:0] k, input logic [63:0] b, input logic [1:0] m,
                        input logic [63:0] e);
      @(posedge clk); #1;
      req_key = k; req_blk = b; req_mode = m; exp_next = e; req_valid = 1'b1;
   endtask

   task automatic wait_acc();
      bit ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1;
      end
      if (!ok) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = rsp_cnt;
      bit ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk); #1;
         if (rsp_cnt != n) ok = 1;
      end
      if (!ok) chk("rsp_timeout", 64'd1, 64'd0);
   endtask

   task automatic req(input logic [79:0] k, input logic [63:0] b, input logic [1:0] m,
                      input logic [63:0] e);
      drive(k, b, m, e);
      wait_acc();
      wait_rsp();
   endtask

   task automatic chk_log(input string t, input logic [31:0] cw, input logic [3:0] ahi,
                          input logic [3:0] alo, input logic [79:0] k, input logic [63:0] b);
      logic [3:0]  wa [7] = '{4'h3, 4'h2, 4'h1, 4'h5, 4'h4, 4'h8, 4'h0};
      logic [31:0] wd [7];
      int hi = 0;
      wd = '{k[79:48], k[47:16], {16'h0, k[15:0]}, b[63:32], b[31:0], cw, 32'h1};
      chk({t, "_loglen"}, 64'(log_q.size()), 64'(LAT));
      if (log_q.size() == LAT) begin
         for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_wr%0d", t, i), 64'({log_q[i].cs, log_q[i].wr, log_q[i].rd, log_q[i].a}),
                64'({3'b001, wa[i]}));
            chk($sformatf("%s_wd%0d", t, i), 64'(log_q[i].d), 64'(wd[i]));
         end
         chk({t, "_release"}, 64'({log_q[7].cs, log_q[7].wr, log_q[7].rd, log_q[7].a}), 64'({3'b011, 4'h0}));
         for (int i = 8; i < 8 + WAIT_CYCLES; i++) if (log_q[i].cs) hi++;
         chk({t, "_wait_cs"}, 64'(hi), 64'(WAIT_CYCLES));
         chk({t, "_rd_hi"}, 64'({log_q[LAT-4].cs, log_q[LAT-4].wr, log_q[LAT-4].rd, log_q[LAT-4].a}),
             64'({3'b010, ahi}));
         chk({t, "_rd_lo"}, 64'({log_q[LAT-3].cs, log_q[LAT-3].wr, log_q[LAT-3].rd, log_q[LAT-3].a}),
             64'({3'b010, alo}));
         chk({t, "_tail_cs"}, 64'({log_q[LAT-2].cs, log_q[LAT-1].cs}), 64'(2'b11));
      end
      chk({t, "_load_pulse"}, 64'(load_cnt), 64'd1);
   endtask

   // ---------------- test sequence ----------------
   localparam logic [63:0] V0 = 64'h5579C1387B228445;
   localparam logic [63:0] V1 = 64'hE72C46C0F5945049;

   initial begin
      logic [95:0] r96;
      logic [79:0] k;
      logic [63:0] b, d0;
      logic [1:0]  m;
      int n0, bad, cnt, acc0;

      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      req_key = '0; req_blk = '0; req_mode = '0; exp_next = '0;
      repeat (3) @(negedge clk);
      chk("rst_strobes", 64'({cs_n, wr_n, rd_n}), 64'(3'b111));
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_wdat", 64'(wdat), 64'd0);
      chk("rst_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rspdata", rsp_data, 64'd0);
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clk); #1 rst = 1'b0;

      req(80'h0, 64'h0, 2'd0, V0);
      chk_log("enc0", 32'h0, 4'h7, 4'h6, 80'h0, 64'h0);
      req({80{1'b1}}, 64'h0, 2'd0, V1);
      chk_log("encF", 32'h0, 4'h7, 4'h6, {80{1'b1}}, 64'h0);
      req(80'h0, V0, 2'd1, 64'h0);
      chk_log("dec0", 32'h1, 4'h7, 4'h6, 80'h0, V0);

      r96 = {$urandom(), $urandom(), $urandom()}; k = r96[79:0];
      b = {$urandom(), $urandom()};
      req(k, b, 2'd3, enc(k, b));
      chk_log("mode3", 32'h0, 4'h7, 4'h6, k, b);
      req(k, b, 2'd2, enc(k, b) ^ b);
      chk_log("dm", 32'h0, 4'hA, 4'h9, k, b);

      for (int i = 0; i < 3; i++) begin
         r96 = {$urandom(), $urandom(), $urandom()}; k = r96[79:0];
         b = {$urandom(), $urandom()};
         m = 2'($urandom_range(0, 2));
         req(k, b, m, (m == 2'd0) ? enc(k, b) : (m == 2'd1) ? dec(k, b) : enc(k, b) ^ b);
      end

      // Backpressure with a second request held valid throughout.
      drive(80'h0, 64'h0, 2'd0, V0);
      wait_acc();
      rsp_ready = 1'b0;
      drive({80{1'b1}}, 64'h0, 2'd0, V1);
      acc0 = acc_cnt;
      bad = 1;
      for (int i = 0; i < 300 && bad != 0; i++) begin
         @(negedge clk);
         if (rsp_valid) bad = 0;
      end
      chk("bp_rsp_seen", 64'(bad), 64'd0);
      d0 = rsp_data;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== d0 || req_ready) bad++;
      end
      chk("bp_stable", 64'(bad), 64'd0);
      chk("bp_no_accept", 64'(acc_cnt - acc0), 64'd0);
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_acc();
      chk("bp_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
      wait_rsp();

      // Reset during WAIT drops the request.
      drive(80'h0, 64'h0, 2'd0, V0);
      wait_acc();
      n0 = rsp_cnt;
      for (int i = 0; i < 200 && cyc < acc_cyc + 39; i++) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rstw_strobes", 64'({cs_n, wr_n, rd_n}), 64'(3'b111));
      chk("rstw_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      chk("rstw_rsp", {63'd0, rsp_valid}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      cnt = 0;
      repeat (150) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("rstw_no_rsp", 64'(cnt + rsp_cnt - n0), 64'd0);
      chk("rstw_sb_empty", 64'(exp_q.size()), 64'd0);
      req(80'h0, 64'h0, 2'd0, V0);
      chk_log("post_rst", 32'h0, 4'h7, 4'h6, 80'h0, 64'h0);

      chk("accept_total", 64'(acc_cnt), 64'd12);
      chk("bus_rules", 64'(bus_viol), 64'd0);
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
